// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared state enum, point type, defaults and distance helpers for the laser stimulus driver
package laser_pkg;

  localparam int NPTS_DEF = 40;
  localparam int R2_DEF   = 16;

  typedef enum logic [2:0] {
    LOAD,
    CORE_RST,
    STREAM,
    WAIT_DONE,
    SCORE,
    REPORT
  } state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } point_t;

  function automatic logic [7:0] sq4(input logic [3:0] d);
    return {4'd0, d} * {4'd0, d};
  endfunction

  function automatic logic [3:0] absdiff4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// rtl/laser_cover_chk.sv - combinational check of one point against two centres (inclusive radius R2)
module laser_cover_chk
  import laser_pkg::*;
#(
  parameter int R2 = R2_DEF
) (
  input  point_t pt,
  input  point_t c1,
  input  point_t c2,
  output logic   covered
);

  logic [8:0] d1;
  logic [8:0] d2;

  always_comb begin
    d1 = {1'b0, sq4(absdiff4(pt.x, c1.x))} + {1'b0, sq4(absdiff4(pt.y, c1.y))};
    d2 = {1'b0, sq4(absdiff4(pt.x, c2.x))} + {1'b0, sq4(absdiff4(pt.y, c2.y))};
    covered = (d1 <= 9'(R2)) || (d2 <= 9'(R2));
  end

endmodule

// File: rtl/laser_stim_driver.sv
// rtl/laser_stim_driver.sv - frame buffer, core reset/stream sequencer and result capture
// LASER_SCORE_EN builds the SCORE state and coverage counter; otherwise RES_COUNT is 0.
module laser_stim_driver
  import laser_pkg::*;
#(
  parameter int NPTS        = NPTS_DEF,
  parameter int R2          = R2_DEF,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [3:0] IN_X,
  input  logic [3:0] IN_Y,
  input  logic       START,
  output logic       BUSY,
  output logic       L_RST,
  output logic [3:0] L_X,
  output logic [3:0] L_Y,
  input  logic       L_DONE,
  input  logic [3:0] L_C1X,
  input  logic [3:0] L_C1Y,
  input  logic [3:0] L_C2X,
  input  logic [3:0] L_C2Y,
  output logic       RES_VALID,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic [5:0] RES_COUNT,
  output logic       TIMEOUT
);

  localparam int PW = $clog2(NPTS + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  state_t        state, state_n;
  logic [PW-1:0] wr_ptr, wr_ptr_n, ptr;
  logic [WW-1:0] wait_cnt;
  point_t        buf_mem [NPTS];
  logic          wr_en, launch, done_hit, to_hit;
  logic          ready_d, busy_d, lrst_d, valid_d;

  always_comb begin
    wr_en    = (state == LOAD) && IN_VALID && IN_READY;
    // A full buffer cannot also take a write, so a last-point write with START never launches.
    launch   = (state == LOAD) && START && (wr_ptr == PW'(NPTS));
    done_hit = (state == WAIT_DONE) && L_DONE;
    to_hit   = (state == WAIT_DONE) && !L_DONE && (wait_cnt == WW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD:      if (launch) state_n = CORE_RST;
      CORE_RST:  state_n = STREAM;
      STREAM:    if (ptr == PW'(NPTS)) state_n = WAIT_DONE;
      WAIT_DONE: begin
`ifdef LASER_SCORE_EN
        if (done_hit)    state_n = SCORE;
`else
        if (done_hit)    state_n = REPORT;
`endif
        else if (to_hit) state_n = LOAD;
      end
`ifdef LASER_SCORE_EN
      SCORE:     if (ptr == PW'(NPTS - 1)) state_n = REPORT;
`endif
      REPORT:    state_n = LOAD;
      default:   state_n = LOAD;
    endcase
  end

  always_comb begin
    wr_ptr_n = wr_ptr;
    if (wr_en) wr_ptr_n = wr_ptr + PW'(1);
    if (state == REPORT) wr_ptr_n = '0;
    ready_d = (state_n == LOAD) && (wr_ptr_n < PW'(NPTS));
    busy_d  = (state_n != LOAD);
    lrst_d  = (state_n == CORE_RST);
    valid_d = (state_n == REPORT);
  end

  always_ff @(posedge CLK) begin
    if (wr_en) buf_mem[wr_ptr] <= '{x: IN_X, y: IN_Y};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      ptr       <= '0;
      wait_cnt  <= '0;
      IN_READY  <= 1'b0;
      BUSY      <= 1'b0;
      L_RST     <= 1'b1;
      L_X       <= '0;
      L_Y       <= '0;
      RES_VALID <= 1'b0;
      TIMEOUT   <= 1'b0;
      RES_C1X   <= '0;
      RES_C1Y   <= '0;
      RES_C2X   <= '0;
      RES_C2Y   <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      IN_READY  <= ready_d;
      BUSY      <= busy_d;
      L_RST     <= lrst_d;
      RES_VALID <= valid_d;
      TIMEOUT   <= to_hit;
      wait_cnt  <= (state == WAIT_DONE) ? wait_cnt + WW'(1) : '0;
      // Point 0 is preloaded while L_RST is high so it lands on the first cycle after L_RST falls.
      if (state == CORE_RST) begin
        L_X <= buf_mem[0].x;
        L_Y <= buf_mem[0].y;
        ptr <= PW'(1);
      end else if ((state == STREAM) && (ptr < PW'(NPTS))) begin
        L_X <= buf_mem[ptr].x;
        L_Y <= buf_mem[ptr].y;
        ptr <= ptr + PW'(1);
      end else if (state == SCORE) begin
        ptr <= ptr + PW'(1);
      end
      if (done_hit) begin
        RES_C1X <= L_C1X;
        RES_C1Y <= L_C1Y;
        RES_C2X <= L_C2X;
        RES_C2Y <= L_C2Y;
        ptr     <= '0;
      end
    end
  end

`ifdef LASER_SCORE_EN
  point_t     score_pt, c1_pt, c2_pt;
  logic       covered;
  logic [5:0] cnt, cnt_n;

  always_comb begin
    score_pt = buf_mem[ptr];
    c1_pt    = '{x: RES_C1X, y: RES_C1Y};
    c2_pt    = '{x: RES_C2X, y: RES_C2Y};
    cnt_n    = (cnt == 6'(NPTS)) ? cnt : cnt + 6'(covered);
  end

  laser_cover_chk #(.R2(R2)) u_cover_chk (
    .pt      (score_pt),
    .c1      (c1_pt),
    .c2      (c2_pt),
    .covered (covered)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      RES_COUNT <= '0;
    end else if (done_hit) begin
      cnt <= '0;
    end else if (state == SCORE) begin
      cnt <= cnt_n;
      if (ptr == PW'(NPTS - 1)) RES_COUNT <= cnt_n;
    end
  end
`else
  assign RES_COUNT = '0;
`endif

endmodule

// File: tb/tb_laser_stim_driver.sv
// tb/tb_laser_stim_driver.sv - directed bench for laser_stim_driver; expectations follow LASER_SCORE_EN
module tb_laser_stim_driver;

  localparam int NPTS = 40;
`ifdef LASER_SCORE_EN
  localparam int LAT = NPTS + 1;
  localparam bit SC  = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit SC  = 1'b0;
`endif

  logic       CLK, RST, IN_VALID, IN_READY, START, BUSY, L_RST, L_DONE;
  logic       RES_VALID, TIMEOUT;
  logic [3:0] IN_X, IN_Y, L_X, L_Y, L_C1X, L_C1Y, L_C2X, L_C2Y;
  logic [3:0] RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
  logic [5:0] RES_COUNT;

  int n_cmp;
  int n_fail;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       cov;
  } vec_t;

  vec_t       vecs [NPTS];
  logic [3:0] px [NPTS];
  logic [3:0] py [NPTS];

  laser_stim_driver dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_X(IN_X), .IN_Y(IN_Y),
    .START(START), .BUSY(BUSY), .L_RST(L_RST), .L_X(L_X), .L_Y(L_Y), .L_DONE(L_DONE),
    .L_C1X(L_C1X), .L_C1Y(L_C1Y), .L_C2X(L_C2X), .L_C2Y(L_C2Y), .RES_VALID(RES_VALID),
    .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y), .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y),
    .RES_COUNT(RES_COUNT), .TIMEOUT(TIMEOUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_pts(input int n);
    for (int i = 0; i < n; i++) begin
      IN_VALID = 1'b1;
      IN_X = px[i];
      IN_Y = py[i];
      tick;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic fill_ramp;
    for (int k = 0; k < NPTS; k++) begin
      px[k] = 4'(k % 16);
      py[k] = 4'(k / 16);
    end
  endtask

  // START asserted for one cycle t; returns in WAIT_DONE entry cycle t+NPTS+2.
  task automatic stream_check;
    START = 1'b1;
    tick;
    START = 1'b0;
    check("lrst_t1", L_RST, 1);
    check("busy_t1", BUSY, 1);
    for (int k = 0; k < NPTS; k++) begin
      tick;
      check($sformatf("stream_pt%0d", k), {L_RST, L_X, L_Y}, {1'b0, px[k], py[k]});
    end
    tick;
    check("wait_hold_last", {BUSY, L_X, L_Y}, {1'b1, px[NPTS-1], py[NPTS-1]});
  endtask

  task automatic done_and_report(input int delay, input logic [15:0] cents, input int exp_cnt);
    int          first_j;
    int          pulses;
    logic [15:0] got_c;
    logic [5:0]  got_n;
    first_j = -1;
    pulses  = 0;
    got_c   = '0;
    got_n   = '0;
    repeat (delay) tick;
    L_DONE = 1'b1;
    {L_C1X, L_C1Y, L_C2X, L_C2Y} = cents;
    tick;
    L_DONE = 1'b0;
    {L_C1X, L_C1Y, L_C2X, L_C2Y} = 16'hA5C3;
    for (int j = 1; j <= 60; j++) begin
      if (RES_VALID) begin
        pulses++;
        if (first_j < 0) begin
          first_j = j;
          got_c   = {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y};
          got_n   = RES_COUNT;
        end
      end
      tick;
    end
    check("res_valid_latency", first_j, LAT);
    check("res_valid_pulses", pulses, 1);
    check("res_centres", got_c, cents);
    check("res_count", got_n, SC ? exp_cnt : 0);
    check("idle_after_report", {BUSY, IN_READY}, 2'b01);
  endtask

  initial begin
    int exp_cnt;
    int first_j;
    int pulses;

    // Distance-boundary table for C1=(4,0), C2=(15,15).
    vecs[0]  = '{4'd0,  4'd0,  1'b1};
    vecs[1]  = '{4'd1,  4'd3,  1'b0};
    vecs[2]  = '{4'd11, 4'd15, 1'b1};
    vecs[3]  = '{4'd12, 4'd12, 1'b0};
    vecs[4]  = '{4'd4,  4'd0,  1'b1};
    vecs[5]  = '{4'd8,  4'd0,  1'b1};
    vecs[6]  = '{4'd4,  4'd4,  1'b1};
    vecs[7]  = '{4'd5,  4'd4,  1'b0};
    vecs[8]  = '{4'd15, 4'd11, 1'b1};
    vecs[9]  = '{4'd14, 4'd12, 1'b1};
    vecs[10] = '{4'd0,  4'd15, 1'b0};
    for (int i = 11; i < NPTS; i++) begin
      if (i % 2 == 0) vecs[i] = '{4'd4, 4'd2, 1'b1};
      else            vecs[i] = '{4'd8, 4'd8, 1'b0};
    end

    n_cmp = 0;
    n_fail = 0;
    RST = 1'b1;
    IN_VALID = 1'b0;
    IN_X = '0;
    IN_Y = '0;
    START = 1'b0;
    L_DONE = 1'b0;
    {L_C1X, L_C1Y, L_C2X, L_C2Y} = '0;

    tick;
    tick;
    check("rst_ready", IN_READY, 0);
    check("rst_lrst", L_RST, 1);
    check("rst_outs", {BUSY, RES_VALID, TIMEOUT, L_X, L_Y}, 0);
    check("rst_res", {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, RES_COUNT}, 0);
    RST = 1'b0;
    tick;
    check("post_rst", {IN_READY, L_RST, BUSY}, 3'b100);

    // Uniform frame, single centre covers everything.
    for (int k = 0; k < NPTS; k++) begin
      px[k] = 4'd5;
      py[k] = 4'd5;
    end
    load_pts(NPTS);
    check("ready_drop_full", IN_READY, 0);
    stream_check();
    done_and_report(100, 16'h5500, 40);

    // Ramp frame with non-overlapping centres (13 + 8 covered).
    fill_ramp();
    load_pts(NPTS);
    stream_check();
    done_and_report(7, 16'h00F2, 21);

    // Boundary table: START after 39 writes, then with the last write, then alone.
    for (int i = 0; i < NPTS; i++) begin
      px[i] = vecs[i].x;
      py[i] = vecs[i].y;
    end
    load_pts(NPTS - 1);
    START = 1'b1;
    tick;
    START = 1'b0;
    tick;
    check("start_39_ignored", {BUSY, IN_READY}, 2'b01);
    IN_VALID = 1'b1;
    IN_X = px[NPTS-1];
    IN_Y = py[NPTS-1];
    START = 1'b1;
    tick;
    IN_VALID = 1'b0;
    START = 1'b0;
    tick;
    check("start_with_last_write", {BUSY, IN_READY, L_RST}, 3'b000);
    stream_check();
    exp_cnt = 0;
    for (int i = 0; i < NPTS; i++) exp_cnt += int'(vecs[i].cov);
    done_and_report(3, 16'h40FF, exp_cnt);

    // Timeout then re-launch without reloading; coincident centres count each point once.
    fill_ramp();
    load_pts(NPTS);
    stream_check();
    first_j = -1;
    pulses = 0;
    for (int j = 0; j <= 4200; j++) begin
      if (TIMEOUT) begin
        pulses++;
        if (first_j < 0) first_j = j;
      end
      tick;
    end
    check("timeout_cycle", first_j, 4095);
    check("timeout_pulses", pulses, 1);
    check("after_timeout", {BUSY, IN_READY, RES_VALID}, 3'b000);
    stream_check();
    done_and_report(20, 16'h0000, 13);

    // Reset in the middle of streaming.
    for (int k = 0; k < NPTS; k++) begin
      px[k] = 4'd5;
      py[k] = 4'd5;
    end
    load_pts(NPTS);
    START = 1'b1;
    tick;
    START = 1'b0;
    repeat (6) tick;
    RST = 1'b1;
    tick;
    check("midrst_lrst_busy", {L_RST, BUSY}, 2'b10);
    RST = 1'b0;
    tick;
    check("midrst_release", {IN_READY, BUSY, L_RST}, 3'b100);
    START = 1'b1;
    tick;
    START = 1'b0;
    tick;
    check("midrst_wrptr_cleared", {BUSY, L_RST, IN_READY}, 3'b001);
    L_DONE = 1'b1;
    tick;
    L_DONE = 1'b0;
    pulses = 0;
    for (int j = 0; j < 80; j++) begin
      if (RES_VALID || TIMEOUT) pulses++;
      tick;
    end
    check("midrst_no_result", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
